// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: writeback, MDU handshake, issue/decode hazard and register-file write port signals
interface rf_write_scheduler_if #(parameter int DATA_W = 32);
  logic wb_we;
  logic [4:0] wb_wa;
  logic [DATA_W-1:0] wb_wd;
  logic mdu_valid;
  logic mdu_ready;
  logic [4:0] mdu_wa;
  logic [DATA_W-1:0] mdu_wd;
  logic iss_valid;
  logic [4:0] iss_rd;
  logic [4:0] dec_ra1;
  logic [4:0] dec_ra2;
  logic dec_we;
  logic [4:0] dec_wa;
  logic stall;
  logic rf_we3;
  logic [4:0] rf_wa3;
  logic [DATA_W-1:0] rf_wd3;
  logic [31:0] busy;
  modport master (
    output wb_we, wb_wa, wb_wd, mdu_valid, mdu_wa, mdu_wd, iss_valid, iss_rd,
           dec_ra1, dec_ra2, dec_we, dec_wa,
    input  mdu_ready, stall, rf_we3, rf_wa3, rf_wd3, busy
  );
  modport slave (
    input  wb_we, wb_wa, wb_wd, mdu_valid, mdu_wa, mdu_wd, iss_valid, iss_rd,
           dec_ra1, dec_ra2, dec_we, dec_wa,
    output mdu_ready, stall, rf_we3, rf_wa3, rf_wd3, busy
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: register-file write-port arbiter, MDU result FIFO and busy scoreboard; RF_WAW_CHECK_EN adds a WAW decode stall
module rf_write_scheduler #(
  parameter int DATA_W = 32,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  rf_write_scheduler_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} st_t;
  st_t st, st_nxt;
  logic [4:0] fa [4];
  logic [DATA_W-1:0] fd [4];
  logic [1:0] rp, wp;
  logic [2:0] cnt, cnt_nxt;
  logic rdy, nonempty, wb_req, push, pop, hz, stl;
  logic we, src;
  logic [4:0] wa;
  logic [DATA_W-1:0] wd;
  logic [31:0] busy, set_m, clr_m;
  // writeback owns the port; the buffer drains only when writeback is idle, r0 results are dropped
  always_comb begin
    wb_req = bus.wb_we && bus.wb_wa != 5'd0;
    push = bus.mdu_valid && rdy && bus.mdu_wa != 5'd0;
    pop = nonempty && !wb_req;
    cnt_nxt = cnt + 3'(push) - 3'(pop);
  end
  // occupancy state register
  always_ff @(posedge clk) st <= reset ? EMPTY : st_nxt;
  // next occupancy from the post-transfer count
  always_comb st_nxt = cnt_nxt == 3'd0 ? EMPTY : cnt_nxt == 3'(BUF_DEPTH) ? FULL : PARTIAL;
  // ready and drain come from registered occupancy, so a pop never raises ready in the same cycle
  always_comb begin
    rdy = !reset && st != FULL;
    nonempty = st != EMPTY;
  end
  // FIFO pointers and count; reset flushes the buffer
  always_ff @(posedge clk)
    if (reset) begin
      rp <= 2'd0;
      wp <= 2'd0;
      cnt <= 3'd0;
    end else begin
      rp <= pop ? (rp == 2'(BUF_DEPTH - 1) ? 2'd0 : rp + 2'd1) : rp;
      wp <= push ? (wp == 2'(BUF_DEPTH - 1) ? 2'd0 : wp + 2'd1) : wp;
      cnt <= cnt_nxt;
    end
  // FIFO entry storage
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= bus.mdu_wa;
      fd[wp] <= bus.mdu_wd;
    end
  // registered write port; src marks writes that came from the MDU buffer
  always_ff @(posedge clk)
    if (reset) begin
      we <= 1'b0;
      wa <= 5'd0;
      wd <= '0;
      src <= 1'b0;
    end else begin
      we <= wb_req || pop;
      wa <= wb_req ? bus.wb_wa : pop ? fa[rp] : 5'd0;
      wd <= wb_req ? bus.wb_wd : pop ? fd[rp] : '0;
      src <= pop;
    end
  // decode hazard stall from registered scoreboard and current decode inputs
  always_comb begin
    hz = (busy[bus.dec_ra1] && bus.dec_ra1 != 5'd0) || (busy[bus.dec_ra2] && bus.dec_ra2 != 5'd0) ||
         (bus.iss_valid && busy[bus.iss_rd]);
`ifdef RF_WAW_CHECK_EN
    hz = hz || (bus.dec_we && bus.dec_wa != 5'd0 && busy[bus.dec_wa]);
`endif
    stl = !reset && hz;
  end
`ifndef RF_WAW_CHECK_EN
  logic unused_dec;
  assign unused_dec = ^{bus.dec_we, bus.dec_wa};
`endif
  // scoreboard set on accepted issue, clear one cycle after the MDU write lands
  always_comb begin
    set_m = (bus.iss_valid && !stl && bus.iss_rd != 5'd0) ? 32'd1 << bus.iss_rd : 32'd0;
    clr_m = (we && src) ? 32'd1 << wa : 32'd0;
  end
  // scoreboard register; set wins over clear, r0 never busy
  always_ff @(posedge clk) busy <= reset ? 32'd0 : ((busy & ~clr_m) | set_m) & 32'hFFFF_FFFE;
  assign bus.mdu_ready = rdy;
  assign bus.stall = stl;
  assign bus.rf_we3 = we;
  assign bus.rf_wa3 = wa;
  assign bus.rf_wd3 = wd;
  assign bus.busy = busy;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler: vector table, reset corner sequence and random run against a queue-based model
module tb_rf_write_scheduler;
  localparam int DW = 32;
  localparam int BD = 2;
`ifdef RF_WAW_CHECK_EN
  localparam bit WAW = 1'b1;
`else
  localparam bit WAW = 1'b0;
`endif
  typedef struct {
    logic wbe; logic [4:0] wba; logic [31:0] wbd;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic iv; logic [4:0] ir; logic [4:0] r1; logic [4:0] r2; logic dw; logic [4:0] da;
    logic es; logic er; logic ew; logic [4:0] ea; logic [31:0] ed; logic [31:0] eb;
  } vec_t;
  typedef struct packed {logic [4:0] wa; logic [31:0] wd;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  vec_t tv [24];
  vec_t idle;
  always #5 clk = ~clk;
  rf_write_scheduler_if #(.DATA_W(DW)) bus ();
  rf_write_scheduler #(.DATA_W(DW), .BUF_DEPTH(BD)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic apply(input vec_t v);
    bus.wb_we = v.wbe; bus.wb_wa = v.wba; bus.wb_wd = v.wbd;
    bus.mdu_valid = v.mv; bus.mdu_wa = v.ma; bus.mdu_wd = v.md;
    bus.iss_valid = v.iv; bus.iss_rd = v.ir;
    bus.dec_ra1 = v.r1; bus.dec_ra2 = v.r2; bus.dec_we = v.dw; bus.dec_wa = v.da;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_port(input string n, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    chk({n, " rf_we3"}, 32'(bus.rf_we3), 32'(ew));
    if (ew) begin
      chk({n, " rf_wa3"}, 32'(bus.rf_wa3), 32'(ea));
      chk({n, " rf_wd3"}, bus.rf_wd3, ed);
    end
  endtask
  initial begin
    ent_t q[$];
    ent_t e;
    logic [31:0] mb;
    logic m_we, m_src, ex_stall, ex_rdy;
    logic [4:0] m_wa;
    logic [31:0] m_wd;
    vec_t v;
    idle = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[0]  = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[1]  = '{0,0,0, 0,0,0, 1,8,0,0,0,0, 0,1,0,0,0,0};
    tv[2]  = '{0,0,0, 0,0,0, 0,0,8,0,0,0, 1,1,0,0,0,32'h100};
    tv[3]  = '{0,0,0, 1,8,32'h12345678, 0,0,8,0,0,0, 1,1,0,0,0,32'h100};
    tv[4]  = '{0,0,0, 0,0,0, 0,0,8,0,0,0, 1,1,0,0,0,32'h100};
    tv[5]  = '{0,0,0, 0,0,0, 0,0,0,8,0,0, 1,1,1,8,32'h12345678,32'h100};
    tv[6]  = '{0,0,0, 0,0,0, 0,0,0,8,0,0, 0,1,0,0,0,0};
    tv[7]  = '{1,1,32'h100, 1,3,32'hA, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[8]  = '{1,1,32'h101, 1,4,32'hB, 0,0,0,0,0,0, 0,1,1,1,32'h100,0};
    tv[9]  = '{1,1,32'h102, 1,5,32'hC, 0,0,0,0,0,0, 0,0,1,1,32'h101,0};
    tv[10] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,1,1,32'h102,0};
    tv[11] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,1,3,32'hA,0};
    tv[12] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,1,4,32'hB,0};
    tv[13] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[14] = '{1,5,1, 1,6,2, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[15] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,1,5,1,0};
    tv[16] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,1,6,2,0};
    tv[17] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[18] = '{0,0,0, 1,0,32'hDEAD, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[19] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[20] = '{0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0,0};
    tv[21] = '{0,0,0, 0,0,0, 1,9,0,0,0,0, 0,1,0,0,0,0};
    tv[22] = '{0,0,0, 0,0,0, 1,9,0,0,0,0, 1,1,0,0,0,32'h200};
    tv[23] = '{0,0,0, 0,0,0, 0,0,0,0,1,9, WAW,1,0,0,0,32'h200};
    apply(idle);
    repeat (3) tick();
    chk("reset rf_we3", 32'(bus.rf_we3), 0);
    chk("reset rf_wa3", 32'(bus.rf_wa3), 0);
    chk("reset rf_wd3", bus.rf_wd3, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset mdu_ready", 32'(bus.mdu_ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      apply(tv[i]);
      #3;
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tv[i].es));
      chk($sformatf("v%0d mdu_ready", i), 32'(bus.mdu_ready), 32'(tv[i].er));
      chk($sformatf("v%0d busy", i), bus.busy, tv[i].eb);
      chk_port($sformatf("v%0d", i), tv[i].ew, tv[i].ea, tv[i].ed);
      tick();
    end
    v = idle; v.wbe = 1; v.wba = 2; v.wbd = 32'h55; v.mv = 1; v.ma = 7; v.md = 32'h77;
    apply(v);
    tick();
    v = idle; v.r1 = 9;
    apply(v);
    reset = 1'b1;
    #3;
    chk("midreset stall", 32'(bus.stall), 0);
    chk("midreset mdu_ready", 32'(bus.mdu_ready), 0);
    tick();
    chk("midreset rf_we3", 32'(bus.rf_we3), 0);
    chk("midreset rf_wa3", 32'(bus.rf_wa3), 0);
    chk("midreset rf_wd3", bus.rf_wd3, 0);
    chk("midreset busy", bus.busy, 0);
    chk("midreset stall2", 32'(bus.stall), 0);
    reset = 1'b0;
    #3;
    chk("postreset mdu_ready", 32'(bus.mdu_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flushed c%0d rf_we3", i), 32'(bus.rf_we3), 0);
    end
    v = idle; v.mv = 1; v.ma = 9; v.md = 32'h99;
    apply(v);
    tick();
    apply(idle);
    chk_port("post N+1", 0, 0, 0);
    tick();
    chk_port("post N+2", 1, 9, 32'h99);
    chk("post busy", bus.busy, 0);
    tick();
    chk_port("post N+3", 0, 0, 0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    q.delete();
    mb = 0; m_we = 0; m_src = 0; m_wa = 0; m_wd = 0;
    for (int c = 0; c < 2000; c++) begin
      v = idle;
      v.wbe = $urandom_range(0, 3) == 0; v.wba = 5'($urandom_range(0, 7)); v.wbd = $urandom;
      v.mv = 1'($urandom_range(0, 1)); v.ma = 5'($urandom_range(0, 7)); v.md = $urandom;
      v.iv = $urandom_range(0, 3) == 0; v.ir = 5'($urandom_range(0, 7));
      v.r1 = 5'($urandom_range(0, 7)); v.r2 = 5'($urandom_range(0, 7));
      v.dw = 1'($urandom_range(0, 1)); v.da = 5'($urandom_range(0, 7));
      apply(v);
      #3;
      ex_stall = (v.r1 != 0 && mb[v.r1]) || (v.r2 != 0 && mb[v.r2]) || (v.iv && mb[v.ir]) ||
                 (WAW && v.dw && v.da != 0 && mb[v.da]);
      ex_rdy = q.size() != BD;
      chk($sformatf("rnd%0d stall", c), 32'(bus.stall), 32'(ex_stall));
      chk($sformatf("rnd%0d mdu_ready", c), 32'(bus.mdu_ready), 32'(ex_rdy));
      chk($sformatf("rnd%0d busy", c), bus.busy, mb);
      chk_port($sformatf("rnd%0d", c), m_we, m_wa, m_wd);
      if (m_we && m_src) mb[m_wa] = 1'b0;
      if (v.iv && !ex_stall && v.ir != 0) mb[v.ir] = 1'b1;
      if (v.wbe && v.wba != 0) begin
        m_we = 1; m_src = 0; m_wa = v.wba; m_wd = v.wbd;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_we = 1; m_src = 1; m_wa = e.wa; m_wd = e.wd;
      end else begin
        m_we = 0; m_src = 0;
      end
      if (v.mv && ex_rdy && v.ma != 0) q.push_back('{wa: v.ma, wd: v.md});
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Write-port scheduler and scoreboard for the pipelined MIPS 32x32 register file. It arbitrates the single register-file write port between the pipeline writeback stage and a long-latency multiply/divide unit (MDU). It buffers MDU results until the port is free and tracks which registers have an outstanding MDU result. It drives the decode-stage stall so that no instruction reads a register before its MDU result is written.

## Interface
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- Parameters:
  - `DATA_W`, default 32: register data width.
  - `BUF_DEPTH`, default 2: MDU result buffer entries; legal values 1–4.
- Ports:
  - `clk` in 1: clock.
  - `reset` in 1: synchronous, active-high.
  - `wb_we` in 1: writeback write request.
  - `wb_wa` in 5: writeback destination.
  - `wb_wd` in DATA_W: writeback data.
  - `mdu_valid` in 1: MDU result valid.
  - `mdu_ready` out 1: scheduler can accept an MDU result.
  - `mdu_wa` in 5: MDU destination.
  - `mdu_wd` in DATA_W: MDU data.
  - `iss_valid` in 1: decode issues an MDU op this cycle (qualified by `!stall`).
  - `iss_rd` in 5: destination of the issued MDU op.
  - `dec_ra1`, `dec_ra2` in 5: decode source registers.
  - `dec_we` in 1: decode instruction writes a register.
  - `dec_wa` in 5: its destination.
  - `stall` out 1: freeze fetch/decode.
  - `rf_we3` out 1, `rf_wa3` out 5, `rf_wd3` out DATA_W: register-file write port.
  - `busy` out 32: scoreboard; bit 0 is always 0.

## Operation
- **Priority.** Writeback always wins and is never stalled or buffered.
  - `wb_we && wb_wa != 0` → port granted to WB.
  - `wb_wa == 0` counts as no request.
- **MDU buffer.** FIFO of `BUF_DEPTH` entries. Count states: EMPTY, PARTIAL, FULL.
  - `mdu_ready = (count != BUF_DEPTH)`, derived from registered count only. A same-cycle pop does not raise `mdu_ready`.
  - Handshake: transfer occurs when `mdu_valid && mdu_ready`.
  - `mdu_wa == 0` is accepted but discarded: no entry is made and no write occurs.
- **Drain.** The head entry is popped when the buffer is non-empty and WB is not requesting. Push and pop may occur in the same cycle; count is unchanged and FIFO order is preserved.
- **Scoreboard.**
  - `busy[iss_rd]` is set when `iss_valid && !stall && iss_rd != 0`.
  - `busy[r]` is cleared on the cycle *after* the cycle in which `rf_we3` writes r from the MDU path, so decode never races the register-file write.
  - Same-cycle set and clear of one register: set wins.
- **Stall.** Combinational:
  - asserted when `(busy[dec_ra1] && dec_ra1 != 0) || (busy[dec_ra2] && dec_ra2 != 0)`;
  - also asserted when `iss_valid && busy[iss_rd]`, so a register has at most one outstanding MDU op.
- **Reset mid-operation.** Buffer is flushed, scoreboard is cleared, and the write port is idled. MDU results arriving after reset are written normally; their scoreboard clear is a no-op.

## Timing
- Reset values: `rf_we3=0`, `rf_wa3=0`, `rf_wd3=0`, `busy=0`, `stall=0`, `mdu_ready=0` during reset. `mdu_ready` goes to 1 in the first cycle after reset deasserts.
- Write-port outputs are registered:
  - WB request in cycle N → `rf_we3=1` with WB address and data in N+1.
  - MDU push in cycle N, buffer empty, WB idle in N+1 → `rf_we3` in N+2; `busy` bit low in N+3.
- Sustained WB requests starve the buffer. This is accepted behaviour; the MDU sees backpressure through `mdu_ready`.
- `stall` depends on registered `busy` plus current-cycle decode inputs; it has no path from `mdu_*` or `wb_*`.

## Configuration
- `RF_WAW_CHECK_EN` defined:
  - `stall` additionally asserts when `dec_we && dec_wa != 0 && busy[dec_wa]`.
  - A pipeline write to a register with a pending MDU result is held in decode until that result lands.
- Not defined:
  - No WAW stall.
  - A WB write to a busy register proceeds; the later MDU write then overwrites it, and program order is the software's responsibility.

## Test plan
- Reset, then idle: `busy=0`, `stall=0`, `rf_we3=0`; `mdu_ready` rises in cycle 1.
- Issue MDU op to r8; decode reads r8 → `stall=1`. MDU returns 0x12345678 with WB idle → `rf_we3/rf_wa3=8/rf_wd3=0x12345678` two cycles later. `busy[8]` drops one cycle after that, and `stall` deasserts.
- Fill buffer (`BUF_DEPTH=2`) with r3=0xA, r4=0xB while `wb_we=1` every cycle → `mdu_ready=0`, no MDU write. Drop `wb_we` → writes r3 then r4 in consecutive cycles.
- Same-cycle WB write r5=0x1 and MDU push r6=0x2 → r5 written at N+1, r6 at N+2.
- MDU result to r0 → handshake completes, no `rf_we3`, buffer count unchanged.
- With `RF_WAW_CHECK_EN`: r9 busy, `dec_we=1`, `dec_wa=9` → `stall=1`. Without the macro → `stall=0`.
